i2c_master_arbiter: RTL and testbench
=====================================

# i2c_master_arbiter

Two-port round-robin arbiter and sequencer that shares one `i2c_master` between two independent requesters (e.g. a sensor poller and a configuration engine). It latches the winning requester's command, drives the master's `start`/`read_nwrite`/address/`data_size` inputs, routes the master's per-byte data handshakes to the owner only, and reports completion or a start timeout. It sits between the requesters and `i2c_master`; SCL/SDA are untouched.

## Interface
- `TIMEOUT_CYCLES`, default 4096: `clk` cycles allowed for the master to accept a start (drop `ready`) before abort; must be >= 2.
- `clk` in 1: system clock, same clock as `i2c_master`.
- `rst` in 1: reset, asynchronous, active-high.
- `req0`, `req1` in 1: level request; held high while a transaction is wanted.
- `rnw0`, `rnw1` in 1: read_nwrite per requester, sampled at grant.
- `addr0`, `addr1` in 7: target address, sampled at grant.
- `size0`, `size1` in 3: data_size, sampled at grant, passed to master unmodified.
- `wdata0`, `wdata1` in 8: write data, live (not latched), muxed to master by owner.
- `busy0`, `busy1` out 1: requester owns the master (START through DONE).
- `done0`, `done1` out 1: one-cycle pulse, transaction finished.
- `dreq0`, `dreq1` out 1: owner-gated copy of master `data_request`.
- `dav0`, `dav1` out 1: owner-gated copy of master `data_available`.
- `timeout` out 1: one-cycle pulse, start not accepted in time.
- `rdata` out 8: master `data_o`, shared by both requesters.
- `m_start` out 1, `m_rnw` out 1, `m_addr` out 7, `m_size` out 3, `m_wdata` out 8: to master.
- `m_ready` in 1, `m_data_request` in 1, `m_data_available` in 1, `m_data_o` in 8: from master.

## Operation
- States: IDLE, START, XFER, DONE.
- IDLE: if `m_ready`=1 and any `req` high, grant: single requester wins directly; both high -> the one that is not `last_owner`. Latch owner, rnw/addr/size into `m_rnw`/`m_addr`/`m_size`; -> START. If `m_ready`=0, stay (no grant).
- START: `m_start`=1. `m_ready`=0 sampled -> XFER, `m_start`=0. Counter reaches `TIMEOUT_CYCLES` with `m_ready` still 1 -> `timeout` pulse, `m_start`=0, busy cleared, `last_owner` unchanged, -> IDLE.
- XFER: `dreq`/`dav` of owner follow master combinationally; non-owner held 0. `m_wdata` = owner's `wdata`. `m_ready`=1 sampled -> DONE.
- DONE: owner's `done` pulses, `last_owner` <= owner, -> IDLE.
- `req` still high in IDLE after DONE = new transaction; with both high, owners alternate strictly.
- `dreq`/`dav` are 0 outside XFER. `rdata` always equals `m_data_o`.
- Reset (any time, incl. mid-transaction): state IDLE, `last_owner`=1 (port 0 wins first tie), counter 0; all outputs 0 (`m_start`, `m_rnw`, `m_addr`, `m_size`, busy, done, timeout); gated outputs 0; `rdata`/`m_wdata` follow inputs. Master is reset by the same `rst`.

## Timing
- Grant: req and `m_ready` high at edge k -> `busy`, `m_start`, latched command valid after edge k (1-cycle latency).
- `m_start` held until the edge sampling `m_ready`=0; low after that edge.
- Timeout counter increments every START cycle; abort at edge where count = `TIMEOUT_CYCLES`; `timeout` high exactly one cycle.
- `m_ready` high sampled in XFER at edge j -> DONE for cycle j..j+1; `done` high that one cycle; `busy` low after edge j+1.
- Earliest next grant at edge j+1+1 (one IDLE cycle minimum between transactions).
- `dreq`/`dav` zero added latency vs master.

## Test plan
- Reset: assert `rst` 12 ns mid-XFER -> all busy/done/`m_start` 0 immediately, state IDLE, next tie goes to port 0.
- Single write: `req0`=1, `rnw0`=0, `addr0`=7'h55, `size0`=2, `wdata0`=8'h13, slave at 7'h55 -> `m_addr`=7'h55, two `dreq0` pulses, `dreq1` stays 0, one `done0`, `busy0` low after.
- Single read on port 1: `rnw1`=1, `size1`=2, slave data 8'hCE -> two `dav1` pulses with `rdata`=8'hCE, `dav0` never high, one `done1`.
- Simultaneous: `req0`=`req1`=1 held -> order 0,1,0,1 of `done` pulses, never two busy at once.
- Timeout: `TIMEOUT_CYCLES`=8, `m_ready` forced 1 -> `timeout` pulses 8 cycles after `m_start` rises, `m_start` drops, port 0 regranted next cycle.
- `m_ready`=0 in IDLE with `req0`=1 -> no grant until `m_ready` rises; grant one cycle later.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Two-port round-robin arbiter that shares one i2c_master between two requesters:
// latches the winner's command, sequences start/transfer/done and aborts unaccepted starts.
`timescale 1ns/1ps
module i2c_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       rnw0,
  input  logic       rnw1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [2:0] size0,
  input  logic [2:0] size1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       busy0,
  output logic       busy1,
  output logic       done0,
  output logic       done1,
  output logic       dreq0,
  output logic       dreq1,
  output logic       dav0,
  output logic       dav1,
  output logic       timeout,
  output logic [7:0] rdata,
  output logic       m_start,
  output logic       m_rnw,
  output logic [6:0] m_addr,
  output logic [2:0] m_size,
  output logic [7:0] m_wdata,
  input  logic       m_ready,
  input  logic       m_data_request,
  input  logic       m_data_available,
  input  logic [7:0] m_data_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic          owner;
  logic          last_owner;
  logic [CW-1:0] cnt;
  logic          grant_owner;
  logic          in_xfer;

  // On a tie the port that did not finish the previous transaction wins.
  always_comb begin
    grant_owner = req1;
    if (req0 && req1) grant_owner = ~last_owner;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      timeout    <= 1'b0;
      m_rnw      <= 1'b0;
      m_addr     <= '0;
      m_size     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (m_ready && (req0 || req1)) begin
            owner  <= grant_owner;
            m_rnw  <= grant_owner ? rnw1  : rnw0;
            m_addr <= grant_owner ? addr1 : addr0;
            m_size <= grant_owner ? size1 : size0;
            cnt    <= '0;
            state  <= START;
          end
        end
        START: begin
          // The edge that would bring the count to TIMEOUT_CYCLES aborts instead.
          if (!m_ready) begin
            state <= XFER;
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          if (m_ready) state <= DONE;
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_xfer = (state == XFER);

  // Ownership and handshake routing are decoded straight from state, so an
  // asynchronous reset clears them without waiting for a clock.
  assign busy0   = (state != IDLE) && !owner;
  assign busy1   = (state != IDLE) &&  owner;
  assign done0   = (state == DONE) && !owner;
  assign done1   = (state == DONE) &&  owner;
  assign m_start = (state == START);

  assign dreq0 = in_xfer && !owner && m_data_request;
  assign dreq1 = in_xfer &&  owner && m_data_request;
  assign dav0  = in_xfer && !owner && m_data_available;
  assign dav1  = in_xfer &&  owner && m_data_available;

  assign rdata   = m_data_o;
  assign m_wdata = owner ? wdata1 : wdata0;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a small behavioural i2c_master model.
`timescale 1ns/1ps
module tb_i2c_master_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, rnw0, rnw1;
  logic [6:0] addr0, addr1;
  logic [2:0] size0, size1;
  logic [7:0] wdata0, wdata1;
  logic       busy0, busy1, done0, done1, dreq0, dreq1, dav0, dav1, timeout;
  logic [7:0] rdata;
  logic       m_start, m_rnw;
  logic [6:0] m_addr;
  logic [2:0] m_size;
  logic [7:0] m_wdata;
  logic       m_ready, m_data_request, m_data_available;
  logic [7:0] m_data_o;

  int errors = 0;
  int checks = 0;

  i2c_master_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rnw0(rnw0), .rnw1(rnw1),
    .addr0(addr0), .addr1(addr1), .size0(size0), .size1(size1),
    .wdata0(wdata0), .wdata1(wdata1),
    .busy0(busy0), .busy1(busy1), .done0(done0), .done1(done1),
    .dreq0(dreq0), .dreq1(dreq1), .dav0(dav0), .dav1(dav1),
    .timeout(timeout), .rdata(rdata),
    .m_start(m_start), .m_rnw(m_rnw), .m_addr(m_addr), .m_size(m_size), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_data_request(m_data_request),
    .m_data_available(m_data_available), .m_data_o(m_data_o)
  );

  always #5 clk = ~clk;

  // Behavioural master, updated on the falling edge: accepts a start, emits one
  // handshake pulse per byte with a one-cycle gap, then raises ready again.
  logic       ready_force, ready_val;
  logic       model_ready, model_busy, gap;
  logic [2:0] bytes_left;
  logic [6:0] seen_addr;
  logic [7:0] slave_rdata;

  assign m_ready = ready_force ? ready_val : model_ready;

  always @(negedge clk) begin
    if (rst) begin
      model_ready = 1'b1; model_busy = 1'b0; gap = 1'b0; bytes_left = '0;
      m_data_request = 1'b0; m_data_available = 1'b0; m_data_o = 8'h3C; seen_addr = '0;
    end else if (!ready_force) begin
      m_data_request = 1'b0; m_data_available = 1'b0;
      if (model_busy) begin
        if (gap) gap = 1'b0;
        else if (bytes_left != 0) begin
          if (m_rnw) begin m_data_available = 1'b1; m_data_o = slave_rdata; end
          else m_data_request = 1'b1;
          bytes_left = bytes_left - 3'd1; gap = 1'b1;
        end else begin
          model_ready = 1'b1; model_busy = 1'b0;
        end
      end else if (m_start && model_ready) begin
        model_ready = 1'b0; model_busy = 1'b1; bytes_left = m_size; gap = 1'b1; seen_addr = m_addr;
      end
    end
  end

  // Cumulative event monitor; scenarios compare deltas of these counters.
  int n_dreq0 = 0, n_dreq1 = 0, n_dav0 = 0, n_dav1 = 0, n_done0 = 0, n_done1 = 0, n_both = 0;
  logic [7:0] wdata_at_dreq0 = '0, rdata_at_dav1 = '0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (dreq0) begin n_dreq0++; wdata_at_dreq0 = m_wdata; end
      if (dreq1) n_dreq1++;
      if (dav0)  n_dav0++;
      if (dav1)  begin n_dav1++; rdata_at_dav1 = rdata; end
      if (done0) n_done0++;
      if (done1) n_done1++;
      if (busy0 && busy1) n_both++;
    end
  end

  task automatic cycle;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int port, input string name);
    int n = 0;
    while (((port == 0) ? done0 : done1) !== 1'b1 && n < 100) begin cycle(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL %s: done%0d not seen, waited %0d cycles, limit 100", name, port, n); end
  endtask

  task automatic test_reset;
    rst = 1'b1; ready_force = 1'b0; ready_val = 1'b0;
    req0 = 0; req1 = 0; rnw0 = 0; rnw1 = 0; addr0 = '0; addr1 = '0; size0 = '0; size1 = '0;
    wdata0 = 8'hA5; wdata1 = 8'h5A; slave_rdata = 8'h00;
    repeat (3) cycle();
    checks++; if ({busy0, busy1, done0, done1} !== 4'b0000) begin errors++; $display("FAIL reset_busy_done: got %b want 0000", {busy0, busy1, done0, done1}); end
    checks++; if ({timeout, m_start, m_rnw} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {timeout, m_start, m_rnw}); end
    checks++; if ({m_addr, m_size} !== 10'h000) begin errors++; $display("FAIL reset_cmd: got %h want 000", {m_addr, m_size}); end
    checks++; if ({dreq0, dreq1, dav0, dav1} !== 4'b0000) begin errors++; $display("FAIL reset_gated: got %b want 0000", {dreq0, dreq1, dav0, dav1}); end
    checks++; if (m_wdata !== 8'hA5) begin errors++; $display("FAIL reset_wdata: got %h want a5", m_wdata); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL reset_rdata: got %h want 3c", rdata); end
    rst = 1'b0;
    cycle();
    checks++; if ({busy0, busy1, m_start} !== 3'b000) begin errors++; $display("FAIL idle_no_req: got %b want 000", {busy0, busy1, m_start}); end
  endtask

  task automatic test_single_write;
    int d0 = n_dreq0, d1 = n_dreq1, dv0 = n_dav0, dn0 = n_done0;
    rnw0 = 1'b0; addr0 = 7'h55; size0 = 3'd2; wdata0 = 8'h13; req0 = 1'b1;
    cycle();
    checks++; if ({busy0, busy1, m_start} !== 3'b101) begin errors++; $display("FAIL write_grant: busy0,busy1,m_start got %b want 101", {busy0, busy1, m_start}); end
    checks++; if ({m_rnw, m_addr, m_size} !== {1'b0, 7'h55, 3'd2}) begin errors++; $display("FAIL write_cmd: got rnw=%b addr=%h size=%0d want 0/55/2", m_rnw, m_addr, m_size); end
    req0 = 1'b0;
    wait_done(0, "write_done");
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL write_busy_in_done: got %b want 1", busy0); end
    cycle();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL write_busy_after: got %b want 0", busy0); end
    cycle();
    checks++; if (n_dreq0 - d0 !== 2) begin errors++; $display("FAIL write_dreq0_count: got %0d want 2", n_dreq0 - d0); end
    checks++; if (n_dreq1 - d1 !== 0 || n_dav0 - dv0 !== 0) begin errors++; $display("FAIL write_stray: dreq1=%0d dav0=%0d want 0/0", n_dreq1 - d1, n_dav0 - dv0); end
    checks++; if (n_done0 - dn0 !== 1) begin errors++; $display("FAIL write_done_count: got %0d want 1", n_done0 - dn0); end
    checks++; if (wdata_at_dreq0 !== 8'h13) begin errors++; $display("FAIL write_wdata: got %h want 13", wdata_at_dreq0); end
    checks++; if (seen_addr !== 7'h55) begin errors++; $display("FAIL write_slave_addr: got %h want 55", seen_addr); end
  endtask

  task automatic test_single_read;
    int a0 = n_dav0, a1 = n_dav1, dn1 = n_done1, b = n_both;
    slave_rdata = 8'hCE; rnw1 = 1'b1; addr1 = 7'h3A; size1 = 3'd2; req1 = 1'b1;
    cycle();
    checks++; if ({busy0, busy1, m_rnw, m_addr} !== {1'b0, 1'b1, 1'b1, 7'h3A}) begin errors++; $display("FAIL read_grant: got busy0=%b busy1=%b rnw=%b addr=%h want 0/1/1/3a", busy0, busy1, m_rnw, m_addr); end
    req1 = 1'b0;
    wait_done(1, "read_done");
    repeat (2) cycle();
    checks++; if (n_dav1 - a1 !== 2) begin errors++; $display("FAIL read_dav1_count: got %0d want 2", n_dav1 - a1); end
    checks++; if (n_dav0 - a0 !== 0) begin errors++; $display("FAIL read_dav0_count: got %0d want 0", n_dav0 - a0); end
    checks++; if (rdata_at_dav1 !== 8'hCE) begin errors++; $display("FAIL read_rdata: got %h want ce", rdata_at_dav1); end
    checks++; if (n_done1 - dn1 !== 1 || n_both - b !== 0) begin errors++; $display("FAIL read_done_busy: done1=%0d both=%0d want 1/0", n_done1 - dn1, n_both - b); end
  endtask

  task automatic test_simultaneous;
    int order [4];
    int nd = 0, n = 0, gap_bad = 0, b = n_both;
    logic prev_done = 1'b0;
    rnw0 = 1'b0; rnw1 = 1'b1; size0 = 3'd1; size1 = 3'd1; req0 = 1'b1; req1 = 1'b1;
    while (nd < 4 && n < 400) begin
      cycle(); n++;
      if (prev_done && (busy0 || busy1)) gap_bad++;
      prev_done = done0 | done1;
      if (done0) begin order[nd] = 0; nd++; end
      else if (done1) begin order[nd] = 1; nd++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (nd !== 4) begin errors++; $display("FAIL simul_count: got %0d dones want 4", nd); end
    for (int i = 0; i < nd; i++) begin
      checks++; if (order[i] !== i % 2) begin errors++; $display("FAIL simul_order[%0d]: got port %0d want port %0d", i, order[i], i % 2); end
    end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL simul_idle_gap: got %0d busy cycles right after done want 0", gap_bad); end
    cycle();
    checks++; if (n_both - b !== 0) begin errors++; $display("FAIL simul_both_busy: got %0d cycles want 0", n_both - b); end
  endtask

  task automatic test_timeout;
    int bad = 0;
    ready_force = 1'b1; ready_val = 1'b1; size0 = 3'd1; req0 = 1'b1;
    cycle();
    checks++; if ({m_start, busy0, timeout} !== 3'b110) begin errors++; $display("FAIL to_grant: start,busy0,timeout got %b want 110", {m_start, busy0, timeout}); end
    for (int i = 1; i < 8; i++) begin
      cycle();
      if (m_start !== 1'b1 || timeout !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL to_hold: got %0d early drop/timeout cycles want 0", bad); end
    cycle();
    checks++; if ({timeout, m_start, busy0} !== 3'b100) begin errors++; $display("FAIL to_abort: timeout,start,busy0 got %b want 100", {timeout, m_start, busy0}); end
    cycle();
    checks++; if ({timeout, m_start, busy0} !== 3'b011) begin errors++; $display("FAIL to_regrant: timeout,start,busy0 got %b want 011", {timeout, m_start, busy0}); end
    req0 = 1'b0; ready_force = 1'b0;
    wait_done(0, "to_recover_done");
    cycle();
  endtask

  task automatic test_reset_mid;
    rnw1 = 1'b0; size1 = 3'd2; req1 = 1'b1;
    cycle();
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rmid_grant: busy1 got %b want 1", busy1); end
    req1 = 1'b0;
    repeat (3) cycle();
    rst = 1'b1; #1;
    checks++; if ({busy0, busy1, done0, done1, m_start} !== 5'b00000) begin errors++; $display("FAIL rmid_clear: got %b want 00000", {busy0, busy1, done0, done1, m_start}); end
    checks++; if ({m_addr, m_size, dreq1} !== 11'h000) begin errors++; $display("FAIL rmid_cmd: got %h want 000", {m_addr, m_size, dreq1}); end
    #11; rst = 1'b0;
    cycle();
    req0 = 1'b1; req1 = 1'b1;
    cycle();
    checks++; if ({busy0, busy1, m_start} !== 3'b101) begin errors++; $display("FAIL rmid_tie: busy0,busy1,start got %b want 101", {busy0, busy1, m_start}); end
    req0 = 1'b0; req1 = 1'b0;
    wait_done(0, "rmid_done");
    cycle();
  endtask

  task automatic test_ready_low;
    int bad = 0;
    ready_force = 1'b1; ready_val = 1'b0; rnw1 = 1'b0; size1 = 3'd1; req1 = 1'b1;
    repeat (3) begin
      cycle();
      if (busy1 !== 1'b0 || m_start !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rl_no_grant: got %0d granted cycles want 0", bad); end
    ready_val = 1'b1;
    cycle();
    checks++; if ({busy1, m_start} !== 2'b11) begin errors++; $display("FAIL rl_grant: busy1,start got %b want 11", {busy1, m_start}); end
    req1 = 1'b0; ready_force = 1'b0;
    wait_done(1, "rl_done");
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_ready_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
